// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache with tree pseudo-LRU,
// sitting between a 16-bit CPU port and a 128-bit line physical memory.
module cache_nway #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int OFFSET_W = 4;
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = 16 - OFFSET_W - INDEX_W;
    localparam int WAY_W    = $clog2(WAYS);
    localparam int NODES    = WAYS - 1;

    typedef logic [WAY_W-1:0] way_t;
    typedef logic [NODES-1:0] plru_t;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    logic [127:0]      data_arr  [WAYS][SETS];
    logic [TAG_W-1:0]  tag_arr   [WAYS][SETS];
    logic [WAYS-1:0]   valid_arr [SETS];
    logic [WAYS-1:0]   dirty_arr [SETS];
    plru_t             plru_arr  [SETS];

    state_t              state, next_state;
    way_t                victim_q;
    logic [TAG_W-1:0]    miss_tag_q;
    logic [INDEX_W-1:0]  miss_index_q;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [2:0]          req_word;
    logic                req;
    logic [WAYS-1:0]     hit_vec;
    logic                hit;
    way_t                hit_way;
    logic [WAYS-1:0]     set_valid;
    logic                inv_found;
    way_t                inv_way;
    way_t                miss_way;
    logic                victim_dirty;
    logic [127:0]        hit_line;
    logic [127:0]        merged_line;
    logic                latch_miss;
    logic                wb_done;
    logic                fill;
    logic                unused_addr_bit;

    // Mark every tree node on the way's path as pointing to the other subtree.
    function automatic plru_t plru_touch(input plru_t bits, input way_t way);
        plru_t res;
        int    node;
        int    dir;
        res  = bits;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = (int'(way) >> (WAY_W - 1 - l)) & 1;
            res[WAY_W'(node)] = (dir == 0);
            node = 2 * node + 1 + dir;
        end
        return res;
    endfunction

    function automatic way_t plru_pick(input plru_t bits);
        int node;
        int way;
        int dir;
        node = 0;
        way  = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir  = bits[WAY_W'(node)] ? 1 : 0;
            way  = 2 * way + dir;
            node = 2 * node + 1 + dir;
        end
        return way_t'(way);
    endfunction

    assign req_tag         = mem_address[15 -: TAG_W];
    assign req_index       = mem_address[OFFSET_W +: INDEX_W];
    assign req_word        = mem_address[3:1];
    assign req             = mem_read | mem_write;
    assign unused_addr_bit = mem_address[0];

    for (genvar w = 0; w < WAYS; w++) begin : g_hit
        assign hit_vec[w] = valid_arr[req_index][w] && (tag_arr[w][req_index] == req_tag);
    end

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = way_t'(w);
        end
    end

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        set_valid = valid_arr[req_index];
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = way_t'(w);
            end
        end
        miss_way = inv_found ? inv_way : plru_pick(plru_arr[req_index]);
    end

    assign victim_dirty = valid_arr[req_index][miss_way] & dirty_arr[req_index][miss_way];
    assign hit_line     = data_arr[hit_way][req_index];
    assign mem_rdata    = hit ? hit_line[{req_word, 4'h0} +: 16] : 16'h0000;

    always_comb begin
        merged_line = hit_line;
        if (mem_byte_enable[0]) merged_line[{req_word, 4'h0} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged_line[{req_word, 4'h8} +: 8] = mem_wdata[15:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            victim_q     <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
        end else begin
            state <= next_state;
            if (latch_miss) begin
                victim_q     <= miss_way;
                miss_tag_q   <= req_tag;
                miss_index_q <= req_index;
            end
        end
    end

    always_comb begin
        next_state   = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = '0;
        latch_miss   = 1'b0;
        wb_done      = 1'b0;
        fill         = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                    end else begin
                        latch_miss = 1'b1;
                        next_state = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[victim_q][miss_index_q], miss_index_q, 4'h0};
                pmem_wdata   = data_arr[victim_q][miss_index_q];
                if (pmem_resp) begin
                    wb_done    = 1'b1;
                    next_state = req ? ALLOCATE : IDLE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag_q, miss_index_q, 4'h0};
                if (pmem_resp) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            if (fill) begin
                valid_arr[miss_index_q][victim_q] <= 1'b1;
                dirty_arr[miss_index_q][victim_q] <= 1'b0;
                plru_arr[miss_index_q] <= plru_touch(plru_arr[miss_index_q], victim_q);
            end
            if (wb_done) dirty_arr[miss_index_q][victim_q] <= 1'b0;
            if (mem_resp) begin
                plru_arr[req_index] <= plru_touch(plru_arr[req_index], hit_way);
                if (mem_write) dirty_arr[req_index][hit_way] <= 1'b1;
            end
        end
    end

    // Line storage is never reset; only valid bits decide whether it is used.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_arr[victim_q][miss_index_q] <= pmem_rdata;
            tag_arr[victim_q][miss_index_q]  <= miss_tag_q;
        end else if (mem_resp && mem_write) begin
            data_arr[hit_way][req_index] <= merged_line;
        end
    end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a 2-way and a 4-way instance share one CPU
// stimulus port (selected by sel4) and one line-memory model.
module tb_cache_nway;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel4;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    logic [15:0]  o2_rdata, o4_rdata, o2_paddr, o4_paddr;
    logic         o2_resp, o4_resp, o2_pread, o4_pread, o2_pwrite, o4_pwrite;
    logic [127:0] o2_pwdata, o4_pwdata;

    logic [15:0]  cur_rdata, cur_paddr;
    logic         cur_resp, cur_pread, cur_pwrite;
    logic [127:0] cur_pwdata;

    logic [127:0] backing [4096];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sel4;
        logic [15:0] addr;
        logic        wr;
        logic        both;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        int          exp_fill;
        logic [15:0] exp_fill_addr;
        int          exp_wb;
        logic [15:0] exp_wb_addr;
        logic [15:0] exp_wb_w3;
        int          exp_cyc;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    cache_nway #(.WAYS(2), .SETS(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_address(mem_address),
        .mem_read(mem_read & ~sel4), .mem_write(mem_write & ~sel4),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(o2_rdata), .mem_resp(o2_resp), .pmem_address(o2_paddr),
        .pmem_read(o2_pread), .pmem_write(o2_pwrite), .pmem_wdata(o2_pwdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp & ~sel4)
    );

    cache_nway #(.WAYS(4), .SETS(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .mem_address(mem_address),
        .mem_read(mem_read & sel4), .mem_write(mem_write & sel4),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(o4_rdata), .mem_resp(o4_resp), .pmem_address(o4_paddr),
        .pmem_read(o4_pread), .pmem_write(o4_pwrite), .pmem_wdata(o4_pwdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp & sel4)
    );

    assign cur_rdata  = sel4 ? o4_rdata  : o2_rdata;
    assign cur_resp   = sel4 ? o4_resp   : o2_resp;
    assign cur_paddr  = sel4 ? o4_paddr  : o2_paddr;
    assign cur_pread  = sel4 ? o4_pread  : o2_pread;
    assign cur_pwrite = sel4 ? o4_pwrite : o2_pwrite;
    assign cur_pwdata = sel4 ? o4_pwdata : o2_pwdata;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t rv(logic s, logic [15:0] a, logic [15:0] rd, int nf,
                                logic [15:0] fa, int nw, logic [15:0] wa,
                                logic [15:0] w3, int cyc);
        vec_t v;
        v.sel4 = s; v.addr = a; v.wr = 1'b0; v.both = 1'b0; v.be = 2'b11; v.wd = 16'h0;
        v.exp_rd = rd; v.exp_fill = nf; v.exp_fill_addr = fa; v.exp_wb = nw;
        v.exp_wb_addr = wa; v.exp_wb_w3 = w3; v.exp_cyc = cyc;
        return v;
    endfunction

    function automatic vec_t wv(logic s, logic [15:0] a, logic both, logic [1:0] be,
                                logic [15:0] wd);
        vec_t v;
        v = rv(s, a, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
        v.wr = 1'b1; v.both = both; v.be = be; v.wd = wd;
        return v;
    endfunction

    // One CPU access with a line memory answering every pmem strobe after lat extra cycles.
    task automatic do_access(input logic s, input logic [15:0] addr, input logic wr,
                             input logic both, input logic [1:0] be, input logic [15:0] wd,
                             input int lat, output logic [15:0] rd, output int nf,
                             output logic [15:0] fa, output int nw, output logic [15:0] wa,
                             output logic [127:0] wdat, output int cyc, output logic ok,
                             output logic both_err);
        int wait_cnt;
        @(negedge clk);
        sel4 = s;
        mem_address = addr;
        mem_read = !wr || both;
        mem_write = wr;
        mem_byte_enable = be;
        mem_wdata = wd;
        rd = 16'h0; nf = 0; fa = 16'h0; nw = 0; wa = 16'h0; wdat = '0;
        cyc = -1; ok = 1'b0; both_err = 1'b0; wait_cnt = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            #1;
            if (cur_pread && cur_pwrite) both_err = 1'b1;
            if (cur_resp) begin
                rd = cur_rdata;
                ok = 1'b1;
                cyc = c;
            end else if (cur_pread || cur_pwrite) begin
                if (wait_cnt == 0) begin
                    if (cur_pwrite) begin
                        nw++; wa = cur_paddr; wdat = cur_pwdata;
                    end else begin
                        nf++; fa = cur_paddr;
                    end
                end
                if (wait_cnt == lat) begin
                    pmem_resp = 1'b1;
                    if (cur_pwrite) backing[cur_paddr[15:4]] = cur_pwdata;
                    else pmem_rdata = backing[cur_paddr[15:4]];
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk);
            pmem_resp = 1'b0;
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [15:0]  rd, fa, wa;
        logic [127:0] wdat;
        int           nf, nw, cyc;
        logic         ok, both_err;
        do_access(v.sel4, v.addr, v.wr, v.both, v.be, v.wd, 3, rd, nf, fa, nw, wa, wdat,
                  cyc, ok, both_err);
        chk($sformatf("v%0d_done", i), ok, 1'b1);
        chk($sformatf("v%0d_cycles", i), cyc, v.exp_cyc);
        chk($sformatf("v%0d_fills", i), nf, v.exp_fill);
        chk($sformatf("v%0d_writebacks", i), nw, v.exp_wb);
        chk($sformatf("v%0d_rd_and_wr", i), both_err, 1'b0);
        if (!v.wr) chk($sformatf("v%0d_rdata", i), rd, v.exp_rd);
        if (v.exp_fill > 0) chk($sformatf("v%0d_fill_addr", i), fa, v.exp_fill_addr);
        if (v.exp_wb > 0) begin
            chk($sformatf("v%0d_wb_addr", i), wa, v.exp_wb_addr);
            chk($sformatf("v%0d_wb_word3", i), wdat[63:48], v.exp_wb_w3);
        end
    endtask

    initial begin
        logic         seen;
        logic [127:0] exp_line;

        for (int l = 0; l < 4096; l++)
            for (int w = 0; w < 8; w++) backing[l][w*16 +: 16] = {l[11:0], 4'(w)};
        backing[12'h004][63:48] = 16'hBEEF;

        // 2-way: cold miss, byte write, second way, dirty eviction, re-fill from memory
        vq.push_back(rv(0, 16'h0046, 16'hBEEF, 1, 16'h0040, 0, 16'h0, 16'h0, 5));
        vq.push_back(wv(0, 16'h0046, 0, 2'b01, 16'h1234));
        vq.push_back(rv(0, 16'h0046, 16'hBE34, 0, 16'h0, 0, 16'h0, 16'h0, 0));
        vq.push_back(rv(0, 16'h00C6, 16'h00C3, 1, 16'h00C0, 0, 16'h0, 16'h0, 5));
        vq.push_back(rv(0, 16'h0146, 16'h0143, 1, 16'h0140, 1, 16'h0040, 16'hBE34, 9));
        vq.push_back(rv(0, 16'h0046, 16'hBE34, 1, 16'h0040, 0, 16'h0, 16'h0, 5));
        vq.push_back(rv(0, 16'h0146, 16'h0143, 0, 16'h0, 0, 16'h0, 16'h0, 0));
        vq.push_back(wv(0, 16'h0148, 0, 2'b10, 16'hAB00));
        vq.push_back(rv(0, 16'h0148, 16'hAB44, 0, 16'h0, 0, 16'h0, 16'h0, 0));
        vq.push_back(wv(0, 16'h0148, 1, 2'b11, 16'h5555));
        vq.push_back(rv(0, 16'h0148, 16'h5555, 0, 16'h0, 0, 16'h0, 16'h0, 0));
        // after mid-fill reset
        vq.push_back(rv(0, 16'h00C6, 16'h00C3, 1, 16'h00C0, 0, 16'h0, 16'h0, 5));
        vq.push_back(wv(0, 16'h00C6, 0, 2'b11, 16'h7777));
        vq.push_back(rv(0, 16'h0146, 16'h0143, 1, 16'h0140, 0, 16'h0, 16'h0, 5));
        // after abandoned request: victim already written back, so only a fill
        vq.push_back(rv(0, 16'h0246, 16'h0243, 1, 16'h0240, 0, 16'h0, 16'h0, 5));
        // 4-way PLRU in set 2
        vq.push_back(rv(1, 16'h0020, 16'h0020, 1, 16'h0020, 0, 16'h0, 16'h0, 5));
        vq.push_back(rv(1, 16'h00A0, 16'h00A0, 1, 16'h00A0, 0, 16'h0, 16'h0, 5));
        vq.push_back(rv(1, 16'h0120, 16'h0120, 1, 16'h0120, 0, 16'h0, 16'h0, 5));
        vq.push_back(rv(1, 16'h01A0, 16'h01A0, 1, 16'h01A0, 0, 16'h0, 16'h0, 5));
        vq.push_back(rv(1, 16'h0020, 16'h0020, 0, 16'h0, 0, 16'h0, 16'h0, 0));
        vq.push_back(rv(1, 16'h00A0, 16'h00A0, 0, 16'h0, 0, 16'h0, 16'h0, 0));
        vq.push_back(rv(1, 16'h0120, 16'h0120, 0, 16'h0, 0, 16'h0, 16'h0, 0));
        vq.push_back(rv(1, 16'h01A0, 16'h01A0, 0, 16'h0, 0, 16'h0, 16'h0, 0));
        vq.push_back(rv(1, 16'h0020, 16'h0020, 0, 16'h0, 0, 16'h0, 16'h0, 0));
        vq.push_back(rv(1, 16'h0220, 16'h0220, 1, 16'h0220, 0, 16'h0, 16'h0, 5));
        vq.push_back(rv(1, 16'h0120, 16'h0120, 1, 16'h0120, 0, 16'h0, 16'h0, 5));
        vq.push_back(rv(1, 16'h0020, 16'h0020, 0, 16'h0, 0, 16'h0, 16'h0, 0));
        vq.push_back(rv(1, 16'h0220, 16'h0220, 0, 16'h0, 0, 16'h0, 16'h0, 0));

        rst_n = 1'b0; sel4 = 1'b0; mem_address = 16'h0046; mem_read = 1'b1; mem_write = 1'b0;
        mem_byte_enable = 2'b11; mem_wdata = 16'h0; pmem_rdata = '0; pmem_resp = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_mem_resp", o2_resp, 1'b0);
        chk("rst_mem_rdata", o2_rdata, 16'h0);
        chk("rst_pmem_read", o2_pread, 1'b0);
        chk("rst_pmem_write", o2_pwrite, 1'b0);
        chk("rst_pmem_address", o2_paddr, 16'h0);
        chk("rst_pmem_wdata", o2_pwdata, 128'h0);
        chk("rst4_strobes", {o4_resp, o4_pread, o4_pwrite}, 3'b000);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i, vq[i]);

        // reset while a fill is outstanding
        @(negedge clk);
        sel4 = 1'b0; mem_address = 16'h00C6; mem_read = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (cur_pread) seen = 1'b1;
            else @(negedge clk);
        end
        chk("midrst_reach_fill", seen, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pmem_read", cur_pread, 1'b0);
        chk("midrst_pmem_write", cur_pwrite, 1'b0);
        chk("midrst_pmem_address", cur_paddr, 16'h0);
        chk("midrst_mem_resp", cur_resp, 1'b0);
        mem_read = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 11; i < 14; i++) run_vec(i, vq[i]);

        // stalled writeback, then the CPU drops its request
        @(negedge clk);
        sel4 = 1'b0; mem_address = 16'h0246; mem_read = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (cur_pwrite) seen = 1'b1;
            else @(negedge clk);
        end
        chk("hold_reach_wb", seen, 1'b1);
        exp_line = backing[12'h00C];
        exp_line[63:48] = 16'h7777;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("hold%0d_pmem_write", c), cur_pwrite, 1'b1);
            chk($sformatf("hold%0d_pmem_read", c), cur_pread, 1'b0);
            chk($sformatf("hold%0d_addr", c), cur_paddr, 16'h00C0);
            chk($sformatf("hold%0d_wdata", c), cur_pwdata, exp_line);
            chk($sformatf("hold%0d_mem_resp", c), cur_resp, 1'b0);
            @(negedge clk); #1;
        end
        mem_read = 1'b0;
        pmem_resp = 1'b1;
        backing[12'h00C] = exp_line;
        #1;
        chk("drop_mem_resp", cur_resp, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk("drop_idle_strobes", {cur_pread, cur_pwrite, cur_resp}, 3'b000);
        @(negedge clk); #1;
        chk("drop_still_idle", {cur_pread, cur_pwrite, cur_resp}, 3'b000);

        for (int i = 14; i < vq.size(); i++) run_vec(i, vq[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_nway.md
Name: cache_nway

Overview:
- Parametrised N-way set-associative LC-3b cache: data, tag, valid, dirty and pseudo-LRU storage plus its own control FSM. Successor to the fixed 2-way, externally controlled datapath.
- Sits between the CPU memory port (16-bit words) and physical memory (128-bit lines).
- Write-back, write-allocate. Tree pseudo-LRU replacement. Byte-enabled CPU writes.

Parameters:
- WAYS, 2, associativity. Power of two, 2..8.
- SETS, 8, sets per way. Power of two, 2..64.
- Derived: OFFSET_W=4, INDEX_W=log2(SETS), TAG_W=16-4-INDEX_W (9 at defaults).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_address  in  16  CPU byte address; tag=[15:4+INDEX_W], index=[3+INDEX_W:4], word=[3:1].
- mem_read  in  1  CPU read request; held with address until mem_resp.
- mem_write  in  1  CPU write request; held with address/data/enable until mem_resp.
- mem_byte_enable  in  2  bit0 writes [7:0], bit1 writes [15:8].
- mem_wdata  in  16  CPU write data.
- mem_rdata  out  16  selected word of hitting way; 0 when no hit.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  16  line address, bits [3:0]=0.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_wdata  out  128  victim line.
- pmem_rdata  in  128  fill line.
- pmem_resp  in  1  physical memory completion.

Behaviour:
- Reset (async, rst_n=0):
  - All valid, dirty and PLRU bits clear; FSM to IDLE.
  - mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata and mem_rdata all 0 immediately.
  - Data and tag arrays are not reset.
  - Reset mid-transaction abandons it: pmem strobes drop immediately, no partial line is written, and the CPU request must be reissued.
- Arrays: combinational read by index, synchronous write.
  - hit_w = valid[w] & (tag[w]==req tag).
  - At most one way hits.
- Request qualification: mem_read&mem_write together is treated as a write.
- IDLE, hit:
  - mem_resp=1 in the same cycle (hit latency 0 extra cycles).
  - Read: mem_rdata = word[3:1] of the hit line.
  - Write: merge enabled bytes into the word at the edge; set dirty[hit_way].
  - Both: update PLRU to mark hit_way most-recent. Remain IDLE.
- IDLE, miss:
  - Victim = lowest-index invalid way; else the PLRU victim.
  - Latch victim way at the edge.
  - Go to WRITEBACK if victim valid&dirty, else ALLOCATE. mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag,index,4'h0}, pmem_wdata=victim line.
  - All held stable until pmem_resp.
  - On pmem_resp: clear dirty[victim], go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address={req tag,index,4'h0}.
  - On pmem_resp: write pmem_rdata, tag, valid=1, dirty=0 into the victim, go to IDLE.
  - The retried lookup then hits and responds (miss completes through the normal hit path, including byte-merge for writes).
- pmem_read and pmem_write are never both 1.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- PLRU: per-set tree of WAYS-1 bits.
  - Access sets each node on the path to point away from the accessed way.
  - Victim follows node pointers from the root; bit=0 means left/lower.
  - WAYS=2 degenerates to true LRU.
  - Fills count as accesses.
- Requests deasserted while in WRITEBACK/ALLOCATE: the current pmem transaction completes, then return to IDLE with no mem_resp.

Test Plan:
- WAYS=2, SETS=8. Reset, read 0x0046 → pmem_read with pmem_address=0x0040; return line with word3=0xBEEF after 3 cycles → mem_resp with mem_rdata=0xBEEF; no pmem_write.
- Then write 0x0046, byte_enable=2'b01, wdata=0x1234 → mem_resp in the request cycle, no pmem activity; read 0x0046 → 0xBE34.
- Read 0x00C6 (same set, fills way1), then read 0x0146 → pmem_write at 0x0040 with word3=0xBE34, then pmem_read at 0x0140, then mem_resp.
- Assert rst_n=0 during ALLOCATE → pmem_read=0 before the next clk edge; after release, read 0x00C6 misses (pmem_read asserted).
- WAYS=4: fill one set with tags 0..3, access ways 0,1,2,3,0, then miss in that set → way2 replaced, i.e. a later access to the tag-2 address misses.
- Hold pmem_resp low for 10 cycles during WRITEBACK → mem_resp=0 throughout, and pmem_address/pmem_wdata/pmem_write stay constant.
